// File: rtl/stream_detect_pkg.sv
// Shared types and default sizing for the stream_detect_arbiter block.
package stream_detect_pkg;

   localparam int NUM_CH_DEF      = 4;
   localparam int FRAME_LEN_DEF   = 16;
   localparam int CNT_W_DEF       = 6;
   localparam int TIMEOUT_CYC_DEF = 64;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      SHIFT,
      DRAIN,
      REPORT
   } state_t;

endpackage

// File: rtl/stream_detect_arbiter_rr.sv
// Round-robin arbiter: first requester at or after the pointer wins; the pointer
// moves to one past the last served index when upd is strobed.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         req,
   input  logic                 upd,
   input  logic [$clog2(N)-1:0] last_idx,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_idx,
   output logic                 any
);
   localparam int W = $clog2(N);

   logic [W-1:0] ptr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr <= '0;
      end else if (upd) begin
         ptr <= (int'(last_idx) == N - 1) ? '0 : last_idx + 1'b1;
      end
   end

   always_comb begin
      int           c;
      logic [W-1:0] ci;
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      c       = 0;
      ci      = '0;
      for (int k = 0; k < N; k++) begin
         c = int'(ptr) + k;
         if (c >= N) c = c - N;
         ci = W'(c);
         if (!any && req[ci]) begin
            any     = 1'b1;
            gnt[ci] = 1'b1;
            gnt_idx = ci;
         end
      end
   end

endmodule

// File: rtl/stream_detect_arbiter.sv
// Shares one external "11" detector among NUM_CH frame sources and reports hits per frame.
// Optional result-hold timeout is built when STREAM_DETECT_TIMEOUT_EN is defined.
module stream_detect_arbiter
   import stream_detect_pkg::*;
#(
   parameter int NUM_CH      = NUM_CH_DEF,
   parameter int FRAME_LEN   = FRAME_LEN_DEF,
   parameter int CNT_W       = CNT_W_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_CH-1:0]           req,
   input  logic [NUM_CH*FRAME_LEN-1:0] frame_data,
   output logic [NUM_CH-1:0]           gnt,
   output logic                        det_bit,
   output logic                        det_clr,
   input  logic                        det_hit,
   output logic                        res_valid,
   input  logic                        res_ready,
   output logic [$clog2(NUM_CH)-1:0]   res_ch,
   output logic [CNT_W-1:0]            res_count,
   output logic                        res_drop
);
   localparam int CH_W  = $clog2(NUM_CH);
   localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   if (TIMEOUT_CYC < 1 || (1 << CNT_W) <= FRAME_LEN / 2) begin : g_bad_param
      $error("stream_detect_arbiter: illegal TIMEOUT_CYC or CNT_W too small for FRAME_LEN");
   end

   state_t               state, state_nxt;
   logic [FRAME_LEN-1:0] shreg;
   logic [IDX_W-1:0]     bit_idx;
   logic [NUM_CH-1:0]    arb_gnt;
   logic [CH_W-1:0]      arb_idx;
   logic                 arb_any;
   logic                 take;
   logic                 xfer;
   logic                 drop;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
      if (inc && v != CNT_MAX) return v + 1'b1;
      return v;
   endfunction

   rr_arbiter #(.N(NUM_CH)) u_rr (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .upd      (xfer || drop),
      .last_idx (res_ch),
      .gnt      (arb_gnt),
      .gnt_idx  (arb_idx),
      .any      (arb_any)
   );

   assign take      = (state == IDLE) && arb_any;
   assign gnt       = (state == IDLE) ? arb_gnt : '0;
   assign det_bit   = (state == SHIFT) && shreg[0];
   assign res_valid = (state == REPORT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      xfer      = 1'b0;
      case (state)
         IDLE:    if (arb_any) state_nxt = CLEAR;
         CLEAR:   state_nxt = SHIFT;
         SHIFT:   if (bit_idx == IDX_W'(FRAME_LEN - 1)) state_nxt = DRAIN;
         DRAIN:   state_nxt = REPORT;
         REPORT: begin
            if (res_ready) begin
               xfer      = 1'b1;
               state_nxt = IDLE;
            end else if (drop) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Frame data needs no reset: it is always reloaded before SHIFT reads it.
   always_ff @(posedge clk) begin
      if (take) shreg <= frame_data[int'(arb_idx)*FRAME_LEN +: FRAME_LEN];
      else if (state == SHIFT) shreg <= shreg >> 1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         det_clr   <= 1'b0;
         bit_idx   <= '0;
         res_ch    <= '0;
         res_count <= '0;
      end else begin
         det_clr <= (state_nxt == CLEAR);
         if (take) begin
            bit_idx   <= '0;
            res_ch    <= arb_idx;
            res_count <= '0;
         end else begin
            if (state == SHIFT) bit_idx <= bit_idx + 1'b1;
            if (state == SHIFT || state == DRAIN) res_count <= sat_inc(res_count, det_hit);
         end
      end
   end

`ifdef STREAM_DETECT_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] to_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_cnt   <= '0;
         res_drop <= 1'b0;
      end else begin
         to_cnt   <= (state == REPORT) ? to_cnt + 1'b1 : '0;
         res_drop <= drop;
      end
   end

   // A ready arriving on the timeout cycle wins because drop requires !res_ready.
   assign drop = (state == REPORT) && !res_ready && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
   assign drop     = 1'b0;
   assign res_drop = 1'b0;
`endif

   a_no_sat: assert property (@(posedge clk) disable iff (reset)
      ((state == SHIFT || state == DRAIN) && det_hit) |-> (res_count != CNT_MAX));

   a_gnt_onehot: assert property (@(posedge clk) disable iff (reset)
      $onehot0(gnt));

endmodule

// File: tb/tb_stream_detect_arbiter.sv
// Randomized and directed bench for stream_detect_arbiter with a behavioural "11" detector.
`timescale 1ns/1ps
module tb_stream_detect_arbiter;
   localparam int NUM_CH    = 4;
   localparam int FRAME_LEN = 16;
   localparam int CNT_W     = 6;
`ifdef STREAM_DETECT_TIMEOUT_EN
   localparam int TIMEOUT_CYC = 8;
   localparam int LONG_HOLD   = 5;
`else
   localparam int TIMEOUT_CYC = 64;
   localparam int LONG_HOLD   = 10;
`endif

   logic                        clk = 1'b0;
   logic                        reset;
   logic [NUM_CH-1:0]           req;
   logic [NUM_CH*FRAME_LEN-1:0] frame_data;
   logic [NUM_CH-1:0]           gnt;
   logic                        det_bit, det_clr, det_hit;
   logic                        res_valid, res_ready, res_drop;
   logic [1:0]                  res_ch;
   logic [CNT_W-1:0]            res_count;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int ptr    = 0;
   logic [1:0] det_st;

   stream_detect_arbiter #(
      .NUM_CH(NUM_CH), .FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .frame_data(frame_data), .gnt(gnt),
      .det_bit(det_bit), .det_clr(det_clr), .det_hit(det_hit),
      .res_valid(res_valid), .res_ready(res_ready), .res_ch(res_ch),
      .res_count(res_count), .res_drop(res_drop)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Non-overlapping Moore "11" detector: 0 idle, 1 seen one 1, 2 detected.
   always_ff @(posedge clk or posedge reset) begin
      if (reset || det_clr) det_st <= 2'd0;
      else if (!det_bit)    det_st <= 2'd0;
      else                  det_st <= (det_st == 2'd1) ? 2'd2 : 2'd1;
   end
   assign det_hit = (det_st == 2'd2);

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic int ref_count(input logic [FRAME_LEN-1:0] f);
      int run, n;
      run = 0; n = 0;
      for (int i = 0; i < FRAME_LEN; i++) begin
         if (f[i]) begin
            run++;
            if (run == 2) begin n++; run = 0; end
         end else run = 0;
      end
      return n;
   endfunction

   function automatic int rr_pick(input logic [NUM_CH-1:0] m, input int p);
      for (int k = 0; k < NUM_CH; k++)
         if (m[(p + k) % NUM_CH]) return (p + k) % NUM_CH;
      return -1;
   endfunction

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1; req = '0; res_ready = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0; ptr = 0;
   endtask

   task automatic do_frame(input logic [NUM_CH-1:0] mask, input logic [NUM_CH*FRAME_LEN-1:0] frames,
                           input int hold, input string tag);
      int n, ch, exp_cnt;
      logic busy_gnt, bad;
      @(posedge clk); #1;
      frame_data = frames; req = mask; res_ready = 1'b0;
      ch = rr_pick(mask, ptr);
      exp_cnt = ref_count(frames[ch*FRAME_LEN +: FRAME_LEN]);
      n = 0;
      @(negedge clk);
      while (gnt == '0 && n < 200) begin @(negedge clk); n++; end
      chk({tag, "_gnt"}, 64'(gnt), 64'(1 << ch));
      @(posedge clk); #1 req[ch] = 1'b0;
      @(negedge clk);
      chk({tag, "_clr"}, 64'(det_clr), 64'd1);
      n = 1; busy_gnt = 1'b0;
      while (!res_valid && n < 200) begin
         @(negedge clk); n++;
         if (gnt != '0) busy_gnt = 1'b1;
      end
      chk({tag, "_lat"}, 64'(n), 64'(FRAME_LEN + 3));
      chk({tag, "_busy"}, 64'(busy_gnt), 64'd0);
      chk({tag, "_ch"}, 64'(res_ch), 64'(ch));
      chk({tag, "_cnt"}, 64'(res_count), 64'(exp_cnt));
      bad = 1'b0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if (res_valid !== 1'b1 || res_ch !== 2'(ch) || res_count !== CNT_W'(exp_cnt) || gnt != '0)
            bad = 1'b1;
      end
      if (hold > 0) chk({tag, "_hold"}, 64'(bad), 64'd0);
      @(posedge clk); #1 res_ready = 1'b1;
      @(negedge clk);
      chk({tag, "_xfer"}, 64'({res_valid, res_drop}), 64'(2'b10));
      @(posedge clk); #1;
      res_ready = 1'b0; req = '0;
      ptr = (ch + 1) % NUM_CH;
      @(negedge clk);
      chk({tag, "_idle"}, 64'({res_valid, gnt}), 64'd0);
   endtask

   initial begin : main
      logic [NUM_CH*FRAME_LEN-1:0] frames;
      int gcyc[5];
      int gch[5];
      int ng, n, v, ch, nx;

      reset = 1'b1; req = '0; res_ready = 1'b0; frame_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outs", 64'({gnt, det_bit, det_clr, res_valid, res_ch, res_count, res_drop}), 64'd0);
      @(posedge clk); #1 reset = 1'b0;

      do_frame(4'b0001, {48'h0, 16'h000F}, 0, "ch0_000F");
      do_frame(4'b0010, {32'h0, 16'hC000, 16'h0}, 0, "ch1_C000");
      do_frame(4'b0100, {16'h0, 16'hFFFF, 32'h0}, 1, "ch2_FFFF");
      do_frame(4'b1001, {16'h5555, 48'h0}, LONG_HOLD, "ch3_5555");

      // All channels requesting continuously from reset with ready held high.
      frames = {16'h0F0F, 16'h3333, 16'h7001, 16'hAAAB};
      @(posedge clk); #1;
      reset = 1'b1; req = '1; frame_data = frames;
      @(posedge clk); #1;
      reset = 1'b0; res_ready = 1'b1;
      ng = 0; n = 0;
      while (ng < 5 && n < 200) begin
         @(negedge clk); n++;
         if (res_valid && res_ready)
            chk("b2b_cnt", 64'(res_count), 64'(ref_count(frames[int'(res_ch)*FRAME_LEN +: FRAME_LEN])));
         if (gnt != '0) begin
            gcyc[ng] = cyc;
            gch[ng] = -1;
            for (int j = 0; j < NUM_CH; j++) if (gnt[j]) gch[ng] = j;
            ng++;
         end
      end
      chk("b2b_ngnt", 64'(ng), 64'd5);
      for (int i = 0; i < ng; i++) begin
         chk("b2b_order", 64'(gch[i]), 64'(i % NUM_CH));
         if (i > 0) chk("b2b_space", 64'(gcyc[i] - gcyc[i-1]), 64'(FRAME_LEN + 4));
      end
      @(posedge clk); #1 req = '0;
      n = 0;
      while (!res_valid && n < 100) begin @(negedge clk); n++; end
      chk("b2b_last", 64'(res_count), 64'(ref_count(frames[15:0])));
      @(posedge clk); #1 res_ready = 1'b0;
      ptr = 1;

      for (int it = 0; it < 12; it++) begin
         frames = {$urandom, $urandom};
         do_frame(NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1)), frames,
                  int'($urandom_range(0, 3)), "rand");
      end

`ifdef STREAM_DETECT_TIMEOUT_EN
      ch = ptr; nx = (ptr + 1) % NUM_CH;
      @(posedge clk); #1;
      frame_data = {$urandom, $urandom}; req = NUM_CH'((1 << ch) | (1 << nx)); res_ready = 1'b0;
      n = 0;
      @(negedge clk);
      while (gnt == '0 && n < 200) begin @(negedge clk); n++; end
      chk("to_gnt", 64'(gnt), 64'(1 << ch));
      @(posedge clk); #1 req[ch] = 1'b0;
      n = 0;
      while (!res_valid && n < 200) begin @(negedge clk); n++; end
      v = 0;
      while (res_valid && v < 200) begin v++; @(negedge clk); end
      chk("to_len", 64'(v), 64'(TIMEOUT_CYC));
      chk("to_drop", 64'({res_drop, res_valid, gnt}), 64'({2'b10, NUM_CH'(1 << nx)}));
      @(posedge clk); #1 req = '0;
      @(negedge clk);
      chk("to_pulse", 64'(res_drop), 64'd0);
      do_reset();
`else
      ch = 0; nx = 0; v = 0;
`endif

      // Reset in the fifth SHIFT cycle of a ch2 frame.
      @(posedge clk); #1;
      frame_data = {$urandom, $urandom}; req = 4'b0100;
      n = 0;
      @(negedge clk);
      while (gnt == '0 && n < 200) begin @(negedge clk); n++; end
      chk("mid_gnt", 64'(gnt), 64'(4'b0100));
      @(posedge clk); #1 req = '0;
      repeat (5) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_outs", 64'({gnt, det_bit, det_clr, res_valid, res_ch, res_count, res_drop}), 64'd0);
      @(posedge clk); #1 reset = 1'b0;
      ptr = 0;
      @(negedge clk);
      chk("mid_rst_idle", 64'({res_valid, gnt}), 64'd0);
      do_frame(4'b0101, {$urandom, $urandom}, 1, "post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
